// File: rtl/ritc_vcdl_phase_scanner_pkg.sv
// Shared constants and types for the RITC VCDL phase scanner: tap width,
// scan FSM encoding and the half-scale hit threshold.
package ritc_vcdl_pkg;

    localparam int TAP_BITS = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        LOAD     = 3'd2,
        SETTLE   = 3'd3,
        ACCUM    = 3'd4,
        STORE    = 3'd5,
        FINISH   = 3'd6
    } state_t;

    // Hit count at or above which a tap is considered to sample a 1.
    function automatic int half_count(input int sample_bits);
        return 1 << (sample_bits - 1);
    endfunction

endpackage

// File: rtl/ritc_vcdl_phase_scanner_if.sv
// Scan control, IDELAY drive, loopback sampling and result-RAM read signals
// between control software / IDELAY and the phase scanner.
interface ritc_vcdl_phase_scanner_if
    import ritc_vcdl_pkg::*;
#(
    parameter int SAMPLE_BITS = 8
);
    logic                  start_i;
    logic                  idelayctrl_rdy_i;
    logic                  ref_strobe_i;
    logic                  vcdl_sync_i;
    logic [TAP_BITS-1:0]   delay_o;
    logic                  load_delay_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  error_o;
    logic                  edge_found_o;
    logic [TAP_BITS-1:0]   edge_tap_o;
    logic [TAP_BITS-1:0]   rd_addr_i;
    logic [SAMPLE_BITS:0]  rd_data_o;

    modport slave (
        input  start_i, idelayctrl_rdy_i, ref_strobe_i, vcdl_sync_i, rd_addr_i,
        output delay_o, load_delay_o, busy_o, done_o, error_o,
               edge_found_o, edge_tap_o, rd_data_o
    );

    modport master (
        output start_i, idelayctrl_rdy_i, ref_strobe_i, vcdl_sync_i, rd_addr_i,
        input  delay_o, load_delay_o, busy_o, done_o, error_o,
               edge_found_o, edge_tap_o, rd_data_o
    );
endinterface

// File: rtl/ritc_vcdl_phase_scanner_scan_ram.sv
// Per-tap hit-count store: one synchronous write port, one registered read
// port; a read of the address being written returns the previous contents.
module ritc_vcdl_scan_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/ritc_vcdl_phase_scanner.sv
// Sweeps the loopback IDELAY over all taps, counts sync hits per tap at the
// reference strobe and records the first tap where the sample falls 1 -> 0.
module ritc_vcdl_phase_scanner
    import ritc_vcdl_pkg::*;
#(
    parameter int NUM_TAPS      = 32,
    parameter int SAMPLE_BITS   = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 65535
) (
    input  logic CLK,
    input  logic rst_i,
    ritc_vcdl_phase_scanner_if.slave bus
);
    localparam int CNT_W = SAMPLE_BITS + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'((1 << SAMPLE_BITS) - 1);
    localparam logic [CNT_W-1:0]    HALF_CNT   = CNT_W'(half_count(SAMPLE_BITS));
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [SET_W-1:0]    SETTLE_LD  = SET_W'(SETTLE_CYCLES);
    localparam logic [TAP_BITS-1:0] LAST_TAP   = TAP_BITS'(NUM_TAPS - 1);

    state_t state, state_nxt;

    logic                sync_q;
    logic [TAP_BITS-1:0] tap;
    logic [TAP_BITS-1:0] delay_q;
    logic                error_q;
    logic                edge_found_q;
    logic [TAP_BITS-1:0] edge_tap_q;
    logic [SET_W-1:0]    settle;
    logic [CNT_W-1:0]    strb_cnt;
    logic [CNT_W-1:0]    hits;
    logic [CNT_W-1:0]    prev_hits;
    logic [TMO_W-1:0]    tmo;

    logic accum_last;
    logic tmo_expire;
    logic start_ok;
    logic ram_we;
    logic [CNT_W-1:0] ram_rdata;

    // The strobe that completes the sample window is itself counted.
    assign accum_last = bus.ref_strobe_i && (strb_cnt == LAST_CNT);
    assign tmo_expire = !bus.ref_strobe_i && (tmo == TMO_LAST);
    assign start_ok   = (state == IDLE) && bus.start_i;
    assign ram_we     = (state == STORE);

    always_ff @(posedge CLK) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start_i)          state_nxt = WAIT_RDY;
            WAIT_RDY: if (bus.idelayctrl_rdy_i) state_nxt = LOAD;
            LOAD:                               state_nxt = SETTLE;
            SETTLE:   if (settle == '0)         state_nxt = ACCUM;
            ACCUM: begin
                if (accum_last) begin
                    state_nxt = STORE;
                end else if (tmo_expire) begin
                    state_nxt = FINISH;
                end
            end
            STORE:    state_nxt = (tap == LAST_TAP) ? FINISH : LOAD;
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.load_delay_o = 1'b0;
        bus.done_o       = 1'b0;
        bus.busy_o       = 1'b1;
        bus.delay_o      = delay_q;
        case (state)
            IDLE: bus.busy_o = 1'b0;
            LOAD: begin
                bus.load_delay_o = 1'b1;
                bus.delay_o      = tap;
            end
            // Park the IDELAY back at tap 0 on completion or abort.
            FINISH: begin
                bus.load_delay_o = 1'b1;
                bus.done_o       = 1'b1;
                bus.busy_o       = 1'b0;
                bus.delay_o      = '0;
            end
            default: ;
        endcase
        bus.error_o      = error_q;
        bus.edge_found_o = edge_found_q;
        bus.edge_tap_o   = edge_tap_q;
    end

    always_ff @(posedge CLK) begin
        if (rst_i) begin
            tap          <= '0;
            delay_q      <= '0;
            error_q      <= 1'b0;
            edge_found_q <= 1'b0;
            edge_tap_q   <= '0;
        end else begin
            // edge_tap is cleared too so a scan without a crossing reports 0.
            if (start_ok) begin
                tap          <= '0;
                error_q      <= 1'b0;
                edge_found_q <= 1'b0;
                edge_tap_q   <= '0;
            end
            if (state == LOAD) begin
                delay_q <= tap;
            end
            if (state == ACCUM && tmo_expire && !accum_last) begin
                error_q <= 1'b1;
            end
            if (state == STORE) begin
                if (!edge_found_q && tap != '0 &&
                    prev_hits >= HALF_CNT && hits < HALF_CNT) begin
                    edge_found_q <= 1'b1;
                    edge_tap_q   <= tap;
                end
                if (tap != LAST_TAP) begin
                    tap <= tap + 1'b1;
                end
            end
            if (state == FINISH) begin
                delay_q <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        sync_q <= bus.vcdl_sync_i;
        case (state)
            LOAD: settle <= SETTLE_LD;
            SETTLE: begin
                if (settle != '0) begin
                    settle <= settle - 1'b1;
                end else begin
                    strb_cnt <= '0;
                    hits     <= '0;
                    tmo      <= '0;
                end
            end
            ACCUM: begin
                if (bus.ref_strobe_i) begin
                    strb_cnt <= strb_cnt + 1'b1;
                    hits     <= hits + {{(CNT_W-1){1'b0}}, sync_q};
                    tmo      <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end
            STORE: prev_hits <= hits;
            default: ;
        endcase
    end

    ritc_vcdl_scan_ram #(
        .ADDR_W (TAP_BITS),
        .DATA_W (CNT_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (tap),
        .wdata (hits),
        .raddr (bus.rd_addr_i),
        .rdata (ram_rdata)
    );

    assign bus.rd_data_o = ram_rdata;

endmodule

// File: tb/tb_ritc_vcdl_phase_scanner.sv
// Directed bench for the phase scanner: drives a per-tap hit model and
// checks load sequence, edge detection, RAM contents, timeout and reset.
module tb_ritc_vcdl_phase_scanner;
    import ritc_vcdl_pkg::*;

    localparam int NT   = 32;
    localparam int SB   = 4;
    localparam int FULL = 16;
    localparam int TMO  = 1000;

    localparam int P_STEP   = 0;
    localparam int P_ALL    = 1;
    localparam int P_HALF   = 2;
    localparam int P_GLITCH = 3;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    int   pattern = P_STEP;
    int   sidx = 0;
    int   ph = 0;
    int   kill_tap = -1;
    int   kill_cnt = 0;
    int   last_strobe_edge = 0;
    logic strobe_en = 1'b1;

    ritc_vcdl_phase_scanner_if #(.SAMPLE_BITS(SB)) bus();

    ritc_vcdl_phase_scanner #(
        .NUM_TAPS      (NT),
        .SAMPLE_BITS   (SB),
        .SETTLE_CYCLES (4),
        .TIMEOUT       (TMO)
    ) dut (
        .CLK   (CLK),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic hit_of(input int pat, input int tap, input int s);
        case (pat)
            P_ALL:    return 1'b1;
            P_HALF:   return (tap < 20) ? 1'b1 : ((tap == 20) ? s[0] : 1'b0);
            P_GLITCH: return (tap < 12) && (tap != 3);
            default:  return tap < 12;
        endcase
    endfunction

    // Strobe every 8 cycles; sync follows the model for the current tap.
    always @(negedge CLK) begin
        if (kill_tap < 0) kill_cnt = 0;
        if (strobe_en && kill_cnt < 3) begin
            ph = (ph + 1) % 8;
            bus.ref_strobe_i = (ph == 7);
        end else begin
            bus.ref_strobe_i = 1'b0;
        end
        bus.vcdl_sync_i = hit_of(pattern, int'(bus.delay_o), sidx);
        if (bus.ref_strobe_i) begin
            sidx++;
            if (kill_tap >= 0 && bus.busy_o && int'(bus.delay_o) == kill_tap) begin
                kill_cnt++;
                last_strobe_edge = cyc + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        bus.start_i = 1'b1;
        @(negedge CLK);
        bus.start_i = 1'b0;
    endtask

    task automatic watch_scan(input int budget, input int poke_at,
                              output int loads, output int seq_err, output int dones,
                              output int busy_drops, output int err_cyc);
        loads = 0; seq_err = 0; dones = 0; busy_drops = 0; err_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            bus.start_i = (poke_at >= 0) && (c == poke_at || c == poke_at + 700);
            if (bus.error_o && err_cyc < 0) err_cyc = cyc;
            if (bus.load_delay_o) begin
                if (int'(bus.delay_o) != (bus.done_o ? 0 : loads)) seq_err++;
                loads++;
            end
            if (bus.done_o) begin
                dones++;
                break;
            end
            if (!bus.busy_o) busy_drops++;
        end
        bus.start_i = 1'b0;
    endtask

    task automatic read_ram(input int addr, output logic [31:0] data);
        @(negedge CLK);
        bus.rd_addr_i = addr[TAP_BITS-1:0];
        @(negedge CLK);
        data = 32'(bus.rd_data_o);
    endtask

    task automatic full_scan(input string tag, input int poke_at);
        int loads, seq_err, dones, busy_drops, err_cyc;
        watch_scan(8000, poke_at, loads, seq_err, dones, busy_drops, err_cyc);
        chk({tag, "_loads"}, loads, NT + 1);
        chk({tag, "_seq"}, seq_err, 0);
        chk({tag, "_done"}, dones, 1);
        chk({tag, "_busy"}, busy_drops, 0);
        chk({tag, "_err"}, bus.error_o, 0);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, {bus.done_o, bus.load_delay_o, bus.busy_o}, 0);
    endtask

    initial begin
        logic [31:0] d;
        int loads, seq_err, dones, busy_drops, err_cyc, cnt;
        bit found;

        bus.start_i = 1'b0;
        bus.idelayctrl_rdy_i = 1'b1;
        bus.rd_addr_i = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_load", bus.load_delay_o, 0);
        chk("rst_delay", bus.delay_o, 0);
        chk("rst_error", bus.error_o, 0);
        chk("rst_edge_found", bus.edge_found_o, 0);
        chk("rst_edge_tap", bus.edge_tap_o, 0);
        rst = 1'b0;

        // Step: taps 0..11 hit, 12..31 miss.
        pattern = P_STEP;
        start_pulse();
        full_scan("t1", -1);
        chk("t1_edge_found", bus.edge_found_o, 1);
        chk("t1_edge_tap", bus.edge_tap_o, 12);
        read_ram(5, d);  chk("t1_ram5", d, FULL);
        read_ram(11, d); chk("t1_ram11", d, FULL);
        read_ram(12, d); chk("t1_ram12", d, 0);

        // All taps hit.
        pattern = P_ALL;
        start_pulse();
        full_scan("t2", -1);
        chk("t2_edge_found", bus.edge_found_o, 0);
        chk("t2_edge_tap", bus.edge_tap_o, 0);
        for (int a = 0; a < NT; a++) begin
            read_ram(a, d);
            chk($sformatf("t2_ram%0d", a), d, FULL);
        end

        // Tap 20 exactly half, nothing above.
        pattern = P_HALF;
        start_pulse();
        full_scan("t3a", -1);
        read_ram(20, d); chk("t3a_ram20", d, FULL / 2);
        read_ram(21, d); chk("t3a_ram21", d, 0);
        chk("t3a_edge_found", bus.edge_found_o, 1);
        chk("t3a_edge_tap", bus.edge_tap_o, 21);

        // Glitch at tap 3, recovery, then real crossing at 12.
        pattern = P_GLITCH;
        start_pulse();
        full_scan("t3b", -1);
        read_ram(3, d); chk("t3b_ram3", d, 0);
        read_ram(4, d); chk("t3b_ram4", d, FULL);
        chk("t3b_edge_tap", bus.edge_tap_o, 3);

        // IDELAYCTRL not ready for 100 cycles; stray starts mid-scan.
        pattern = P_STEP;
        bus.idelayctrl_rdy_i = 1'b0;
        start_pulse();
        loads = 0; busy_drops = 0;
        repeat (100) begin
            @(negedge CLK);
            if (bus.load_delay_o) loads++;
            if (!bus.busy_o) busy_drops++;
        end
        chk("t4_no_load", loads, 0);
        chk("t4_busy_wait", busy_drops, 0);
        bus.idelayctrl_rdy_i = 1'b1;
        full_scan("t4", 300);
        chk("t4_edge_tap", bus.edge_tap_o, 12);

        // Strobes stop during tap 7.
        kill_tap = 7;
        start_pulse();
        watch_scan(8000, -1, loads, seq_err, dones, busy_drops, err_cyc);
        chk("t5_loads", loads, 9);
        chk("t5_seq", seq_err, 0);
        chk("t5_done", dones, 1);
        chk("t5_error", bus.error_o, 1);
        chk("t5_tmo_cycles", err_cyc - last_strobe_edge, TMO);
        chk("t5_edge_found", bus.edge_found_o, 0);
        kill_tap = -1;
        @(negedge CLK);
        chk("t5_error_hold", bus.error_o, 1);
        start_pulse();
        chk("t5_error_clr", bus.error_o, 0);
        full_scan("t5b", -1);
        chk("t5b_edge_tap", bus.edge_tap_o, 12);

        // Reset in the middle of tap 9 accumulation.
        start_pulse();
        found = 1'b0;
        for (int c = 0; c < 8000 && !found; c++) begin
            @(negedge CLK);
            if (bus.load_delay_o && bus.delay_o == 9) found = 1'b1;
        end
        chk("t6_reach9", found, 1);
        repeat (30) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        chk("t6_busy", bus.busy_o, 0);
        chk("t6_delay", bus.delay_o, 0);
        chk("t6_load", bus.load_delay_o, 0);
        chk("t6_done", bus.done_o, 0);
        cnt = 0;
        repeat (200) begin
            @(negedge CLK);
            if (bus.done_o || bus.load_delay_o || bus.busy_o) cnt++;
        end
        chk("t6_quiet", cnt, 0);
        start_pulse();
        full_scan("t6b", -1);
        chk("t6b_edge_found", bus.edge_found_o, 1);
        chk("t6b_edge_tap", bus.edge_tap_o, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
